rr_arb_8b: RTL and testbench
============================

# rr_arb_8b

Eight-requester round-robin arbiter with grant lock and acknowledge timeout. It collects request bits from up to eight clients and presents a registered one-hot grant plus its binary index. It rotates priority so that no requester starves. It sits directly upstream of the one-hot consumers in the utils layer and shares their MSB-first priority rule: with a fresh pointer, bit 7 wins.

## Interface
Parameters:
- TIMEOUT, 255: maximum cycles a grant is held without `ack_i`. 0 disables the timeout.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  reset; one clock, synchronous, active-high.
- req_i  in  8  request vector; bit n is client n.
- ack_i  in  1  current grantee has completed; ignored when no grant is active.
- gnt_o  out  8  registered one-hot grant; all-zero when idle.
- gnt_idx_o  out  3  binary index of `gnt_o`; holds the last value when idle.
- gnt_valid_o  out  1  high while `gnt_o` is non-zero.
- timeout_o  out  1  one-cycle pulse when a grant is revoked for timeout.

## Operation
- FSM states: IDLE, GRANT.
- Pointer `last_q[2:0]` is the index of the most recently retired grant. Reset value is 0.
- Arbitration vector `cand` is `req_i`, with the current grantee's bit cleared when in GRANT.
- Masked set `m = cand & ((1 << last_q) - 1)`, i.e. requests strictly below `last_q`.
- Winner selection:
  - If `m != 0`, the winner is the highest set bit of `m`.
  - Else, if `cand != 0`, the winner is the highest set bit of `cand`.
  - Else there is no winner.
- IDLE:
  - winner exists → load `gnt_o`/`gnt_idx_o`, clear the timeout counter, go to GRANT.
  - no winner → stay in IDLE.
- GRANT:
  - The grant is locked; changes in `req_i`, including the grantee dropping its request, do not alter `gnt_o`.
  - `ack_i` = 1:
    - `last_q <= gnt_idx_o`.
    - Re-arbitrate in the same cycle, using `gnt_idx_o` in place of `last_q` for the mask.
    - winner exists → next grant loads directly, back-to-back, and the FSM stays in GRANT.
    - no winner → `gnt_o <= 0`, go to IDLE.
  - `ack_i` = 0 with TIMEOUT ≠ 0 and counter == TIMEOUT−1:
    - Revoke the grant and pulse `timeout_o`.
    - `last_q <= gnt_idx_o`, so the stalled client loses priority.
    - Go to IDLE; there is no same-cycle re-grant.
  - Otherwise, increment the counter, saturating at TIMEOUT−1.
- `ack_i` and timeout expiring in the same cycle: ack wins, and `timeout_o` stays low.
- `rst_i` mid-grant: the grant is dropped at the next edge with no `timeout_o` pulse, and `last_q` returns to 0.
- Reset values: `gnt_o` = 0, `gnt_idx_o` = 0, `gnt_valid_o` = 0, `timeout_o` = 0, state IDLE, counter 0.
- Counter width is `$clog2(TIMEOUT+1)`, minimum 1.

## Timing
- Request-to-grant latency: `req_i` sampled at edge N gives `gnt_o` valid after edge N (visible in cycle N+1).
- Back-to-back: `ack_i` in cycle k gives the next grantee on `gnt_o` in cycle k+1, with no idle bubble.
- Ack with no other requester: `gnt_o` = 0 in cycle k+1; a new request then needs one more cycle.
- Grant duration: at least one cycle; at most TIMEOUT cycles without ack.
- Timeout: `timeout_o` is high in the cycle after revocation, coincident with `gnt_o` = 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `arb_pkg`:
  - state enum `arb_state_t` {IDLE, GRANT};
  - `ARB_N = 8`, `ARB_W = 3`.
- Sub-module `arb_pick_8b`:
  - purely combinational MSB-first picker;
  - inputs: 8-bit vector; outputs: one-hot vector, 3-bit index, any-flag.
  - Instanced twice, once for the masked set and once for the unmasked set.
- Top: FSM, `last_q`, timeout counter, output registers.

## Test plan
- Reset then `req_i` = 8'hFF held, ack every grant: `gnt_idx_o` sequence 7,6,5,4,3,2,1,0,7,… with no bubble and `gnt_valid_o` continuously high.
- `req_i` = 8'b0010_0100, ack every grant, no other requesters: grants alternate 5,2,5,2; with a single requester 8'h04 acked each time, `gnt_o` is 8'h04, then 0 for one cycle, then 8'h04.
- Grant to bit 3, then drop `req_i[3]` without ack while `req_i[6]` is asserted: `gnt_o` stays 8'h08 until ack, then 8'h40 in the following cycle.
- TIMEOUT = 4, `req_i` = 8'h81, never ack:
  - bit 7 is granted for 4 cycles;
  - `timeout_o` pulses with `gnt_o` = 0;
  - the next grant is bit 0.
- TIMEOUT = 4, `ack_i` asserted in the expiry cycle: no `timeout_o` pulse, normal rotation.
- `rst_i` asserted while bit 2 is granted: next cycle all outputs are 0; after release with `req_i` = 8'h84, bit 7 wins.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and sizes for the eight-requester round-robin arbiter.
//   ARB_N       : number of requesters
//   ARB_W       : width of a requester index
//   arb_state_t : arbiter FSM state (IDLE, GRANT)
package arb_pkg;

    localparam int ARB_N = 8;
    localparam int ARB_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/arb_pick_8b.sv
// Purely combinational MSB-first picker.
//   vec    in  8  candidate request vector
//   onehot out 8  one-hot of the highest set bit of vec (zero if vec is zero)
//   idx    out 3  binary index of the highest set bit (zero if vec is zero)
//   any    out 1  vec is non-zero
module arb_pick_8b
    import arb_pkg::*;
(
    input  logic [ARB_N-1:0] vec,
    output logic [ARB_N-1:0] onehot,
    output logic [ARB_W-1:0] idx,
    output logic             any
);

    // Ascending scan: later (higher) set bits overwrite earlier ones, so the MSB wins.
    always_comb begin
        onehot = {ARB_N{1'b0}};
        idx    = {ARB_W{1'b0}};
        any    = |vec;
        for (int i = 0; i < ARB_N; i++) begin
            onehot = vec[i] ? (ARB_N'(1) << i) : onehot;
            idx    = vec[i] ? ARB_W'(i) : idx;
        end
    end

endmodule

// File: rtl/rr_arb_8b.sv
// Eight-requester round-robin arbiter with grant lock and acknowledge timeout.
// Priority rotates downward from the most recently retired grant; with a fresh
// pointer (0) the highest requester wins.
//   clk_i       in  1  clock, rising edge
//   rst_i       in  1  synchronous active-high reset
//   req_i       in  8  request vector, bit n = client n
//   ack_i       in  1  current grantee done (ignored when idle)
//   gnt_o       out 8  registered one-hot grant, zero when idle
//   gnt_idx_o   out 3  index of gnt_o, holds last value when idle
//   gnt_valid_o out 1  gnt_o is non-zero
//   timeout_o   out 1  one-cycle pulse when a grant is revoked for timeout
// TIMEOUT = 0 disables the timeout.
module rr_arb_8b
    import arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [ARB_N-1:0] req_i,
    input  logic             ack_i,
    output logic [ARB_N-1:0] gnt_o,
    output logic [ARB_W-1:0] gnt_idx_o,
    output logic             gnt_valid_o,
    output logic             timeout_o
);

    localparam int            CW     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] T_LAST = (TIMEOUT < 1) ? {CW{1'b0}} : CW'(TIMEOUT - 1);
    localparam logic          TO_EN  = (TIMEOUT != 0);

    arb_state_t       state_q;
    logic [ARB_W-1:0] last_q;
    logic [CW-1:0]    cnt_q;

    logic [ARB_W-1:0] ptr;
    logic [ARB_N-1:0] cand;
    logic [ARB_N-1:0] masked;
    logic [ARB_N-1:0] m_oh;
    logic [ARB_N-1:0] c_oh;
    logic [ARB_W-1:0] m_idx;
    logic [ARB_W-1:0] c_idx;
    logic             m_any;
    logic             c_any;
    logic [ARB_N-1:0] win_oh;
    logic [ARB_W-1:0] win_idx;
    logic             win_any;
    logic             expire;

    // Candidate set and rotation mask. While granting, the only re-arbitration
    // happens on ack, where the retiring grantee becomes the pointer.
    always_comb begin
        ptr    = (state_q == GRANT) ? gnt_idx_o : last_q;
        cand   = req_i & ~((state_q == GRANT) ? gnt_o : {ARB_N{1'b0}});
        masked = cand & ((ARB_N'(1) << ptr) - ARB_N'(1));
    end

    arb_pick_8b u_pick_masked (
        .vec    (masked),
        .onehot (m_oh),
        .idx    (m_idx),
        .any    (m_any)
    );

    arb_pick_8b u_pick_all (
        .vec    (cand),
        .onehot (c_oh),
        .idx    (c_idx),
        .any    (c_any)
    );

    // Requests below the pointer take precedence; otherwise wrap to the top.
    always_comb begin
        win_oh  = m_any ? m_oh : c_oh;
        win_idx = m_any ? m_idx : c_idx;
        win_any = c_any;
        expire  = TO_EN && (cnt_q == T_LAST);
    end

    // Arbiter FSM, rotation pointer, hold counter and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            last_q      <= {ARB_W{1'b0}};
            cnt_q       <= {CW{1'b0}};
            gnt_o       <= {ARB_N{1'b0}};
            gnt_idx_o   <= {ARB_W{1'b0}};
            gnt_valid_o <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            timeout_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_any) begin
                        gnt_o       <= win_oh;
                        gnt_idx_o   <= win_idx;
                        gnt_valid_o <= 1'b1;
                        cnt_q       <= {CW{1'b0}};
                        state_q     <= GRANT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                GRANT: begin
                    if (ack_i) begin
                        last_q <= gnt_idx_o;
                        if (win_any) begin
                            gnt_o     <= win_oh;
                            gnt_idx_o <= win_idx;
                            cnt_q     <= {CW{1'b0}};
                            state_q   <= GRANT;
                        end else begin
                            gnt_o       <= {ARB_N{1'b0}};
                            gnt_valid_o <= 1'b0;
                            state_q     <= IDLE;
                        end
                    end else if (expire) begin
                        // Stalled grantee becomes the pointer so it loses priority.
                        last_q      <= gnt_idx_o;
                        gnt_o       <= {ARB_N{1'b0}};
                        gnt_valid_o <= 1'b0;
                        timeout_o   <= 1'b1;
                        state_q     <= IDLE;
                    end else if (cnt_q != T_LAST) begin
                        cnt_q <= cnt_q + CW'(1);
                    end else begin
                        cnt_q <= cnt_q;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    gnt_o       <= {ARB_N{1'b0}};
                    gnt_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arb_8b.sv
// Self-checking bench for rr_arb_8b (TIMEOUT = 4). A cycle-level model of the
// arbitration rules runs alongside the DUT and is compared every cycle; the
// directed scenarios also pin hand-computed grant values.
module tb_rr_arb_8b;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       ack;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       tout;

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    rr_arb_8b #(.TIMEOUT(T)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .ack_i       (ack),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid),
        .timeout_o   (tout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Search downward from just below ptr, then wrap and search from the top.
    function automatic int pick(input logic [7:0] c, input int ptr);
        for (int i = ptr - 1; i >= 0; i--) if (c[i]) return i;
        for (int i = 7; i >= 0; i--) if (c[i]) return i;
        return -1;
    endfunction

    // Reference model state.
    int m_last  = 0;
    int m_idx   = 0;
    int m_held  = 0;
    bit m_valid = 1'b0;
    bit m_tout  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_last <= 0; m_idx <= 0; m_held <= 0; m_valid <= 1'b0; m_tout <= 1'b0;
        end else if (!m_valid) begin
            m_tout <= 1'b0;
            if (pick(req, m_last) >= 0) begin
                m_valid <= 1'b1;
                m_idx   <= pick(req, m_last);
                m_held  <= 1;
            end
        end else if (ack) begin
            m_tout <= 1'b0;
            m_last <= m_idx;
            if (pick(req & ~(8'd1 << m_idx), m_idx) >= 0) begin
                m_idx  <= pick(req & ~(8'd1 << m_idx), m_idx);
                m_held <= 1;
            end else begin
                m_valid <= 1'b0;
            end
        end else if (m_held == T) begin
            m_valid <= 1'b0;
            m_tout  <= 1'b1;
            m_last  <= m_idx;
        end else begin
            m_held <= m_held + 1;
            m_tout <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("model_gnt", gnt, 32'(m_valid ? (8'd1 << m_idx) : 8'd0));
            check("model_idx", gnt_idx, 32'(m_idx));
            check("model_valid", gnt_valid, 32'(m_valid));
            check("model_tout", tout, 32'(m_tout));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 8'h00; ack = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 8'h00; ack = 1'b0;
        step();
        checking = 1'b1;
        check("rst_gnt", gnt, 32'h0);
        check("rst_idx", gnt_idx, 32'h0);
        check("rst_valid", gnt_valid, 32'h0);
        check("rst_tout", tout, 32'h0);

        // Full rotation with every requester active and every grant acked.
        rst = 1'b0; req = 8'hFF; ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("rot_idx", gnt_idx, 32'(7 - (i % 8)));
            check("rot_valid", gnt_valid, 32'h1);
        end

        // Two requesters alternate.
        do_reset();
        req = 8'b0010_0100; ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("alt_idx", gnt_idx, (i % 2 == 0) ? 32'd5 : 32'd2);
        end

        // Single requester: one idle cycle between grants.
        do_reset();
        req = 8'h04; ack = 1'b1;
        step(); check("single_g1", gnt, 32'h04);
        step(); check("single_gap", gnt, 32'h00);
        step(); check("single_g2", gnt, 32'h04);

        // Grant lock: grantee drops its request, grant holds until ack.
        do_reset();
        req = 8'h08; ack = 1'b0;
        step(); check("lock_g", gnt, 32'h08);
        req = 8'h40;
        step(); check("lock_hold1", gnt, 32'h08);
        step(); check("lock_hold2", gnt, 32'h08);
        ack = 1'b1;
        step(); check("lock_next", gnt, 32'h40);
        ack = 1'b0;

        // Timeout: bit 7 held for T cycles, revoked, then bit 0.
        do_reset();
        req = 8'h81; ack = 1'b0;
        for (int i = 0; i < T; i++) begin
            step();
            check("to_hold", gnt, 32'h80);
            check("to_nopulse", tout, 32'h0);
        end
        step();
        check("to_gnt0", gnt, 32'h00);
        check("to_pulse", tout, 32'h1);
        check("to_valid", gnt_valid, 32'h0);
        step();
        check("to_next", gnt, 32'h01);
        check("to_pulse_end", tout, 32'h0);

        // Ack in the expiry cycle wins over the timeout.
        do_reset();
        req = 8'h81; ack = 1'b0;
        for (int i = 0; i < T; i++) step();
        ack = 1'b1;
        step();
        check("ackexp_gnt", gnt, 32'h01);
        check("ackexp_tout", tout, 32'h0);
        ack = 1'b0;
        step();
        check("ackexp_tout2", tout, 32'h0);

        // Reset mid-grant clears everything and the pointer.
        do_reset();
        req = 8'h04;
        step(); check("rstmid_g", gnt, 32'h04);
        rst = 1'b1;
        step();
        check("rstmid_gnt", gnt, 32'h0);
        check("rstmid_idx", gnt_idx, 32'h0);
        check("rstmid_valid", gnt_valid, 32'h0);
        check("rstmid_tout", tout, 32'h0);
        rst = 1'b0; req = 8'h84;
        step();
        check("rstmid_win", gnt, 32'h80);
        check("rstmid_winidx", gnt_idx, 32'h7);

        req = 8'h00; ack = 1'b1;
        step(); step();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
